// File: rtl/regfile_dump_if.sv
// Beat stream carrying one register (or checksum) value per handshake from regfile_dump.
interface regfile_dump_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  outValid;
  logic                  outReady;
  logic [WIDTH-1:0]      dataOut;
  logic [ADDR_WIDTH-1:0] addrOut;
  logic                  lastOut;

  modport master (
    output outValid,
    output dataOut,
    output addrOut,
    output lastOut,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  dataOut,
    input  addrOut,
    input  lastOut,
    output outReady
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks every regfile address through a shared async read port and streams each value as one beat.
// Optional REGDUMP_CHECKSUM_EN appends a beat carrying the XOR of all register values.
module regfile_dump #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] readAddr,
  input  logic [WIDTH-1:0]      readData,
  regfile_dump_if.master        stream,
  output logic                  busy,
  output logic                  done
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, FINISH} stateT;
  logic [WIDTH-1:0] csumReg;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND, FINISH} stateT;
`endif

  stateT                 stateReg;
  logic [ADDR_WIDTH-1:0] counterReg;
  logic                  outValidReg;
  logic [WIDTH-1:0]      dataOutReg;
  logic [ADDR_WIDTH-1:0] addrOutReg;
  logic                  lastOutReg;
  logic                  busyReg;
  logic                  doneReg;

  // Counter is cleared on reset and in FINISH, so it reads 0 whenever the block is idle.
  assign readAddr        = counterReg;
  assign stream.outValid = outValidReg;
  assign stream.dataOut  = dataOutReg;
  assign stream.addrOut  = addrOutReg;
  assign stream.lastOut  = lastOutReg;
  assign busy            = busyReg;
  assign done            = doneReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg    <= IDLE;
      counterReg  <= '0;
      outValidReg <= 1'b0;
      dataOutReg  <= '0;
      addrOutReg  <= '0;
      lastOutReg  <= 1'b0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csumReg     <= '0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (start) begin
            counterReg <= '0;
            busyReg    <= 1'b1;
            stateReg   <= LOAD;
`ifdef REGDUMP_CHECKSUM_EN
            csumReg    <= '0;
`endif
          end
        end
        LOAD: begin
          dataOutReg  <= readData;
          addrOutReg  <= counterReg;
          outValidReg <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          lastOutReg  <= 1'b0;
          csumReg     <= csumReg ^ readData;
`else
          lastOutReg  <= (counterReg == LAST_ADDR);
`endif
          stateReg    <= SEND;
        end
        SEND: begin
          if (outValidReg && stream.outReady) begin
            outValidReg <= 1'b0;
            if (counterReg == LAST_ADDR) begin
`ifdef REGDUMP_CHECKSUM_EN
              stateReg <= CSUM;
`else
              // done pulses during FINISH, so a start arriving with it is still ignored.
              busyReg  <= 1'b0;
              doneReg  <= 1'b1;
              stateReg <= FINISH;
`endif
            end else begin
              counterReg <= counterReg + 1'b1;
              stateReg   <= LOAD;
            end
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          // First cycle loads the checksum beat, later cycles wait for it to be taken.
          if (!outValidReg) begin
            dataOutReg  <= csumReg;
            addrOutReg  <= '0;
            lastOutReg  <= 1'b1;
            outValidReg <= 1'b1;
          end else if (stream.outReady) begin
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b1;
            stateReg    <= FINISH;
          end
        end
`endif
        FINISH: begin
          counterReg <= '0;
          stateReg   <= IDLE;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end
endmodule
